// File: rtl/cnn_pool_pkg.sv
// Shared parameters for the 2x2 max-pool stage.
// Defaults match the conv/sigmoid feature-map geometry.
package cnn_pool_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_LINE_W   = 26;
  localparam int DEF_ROWS     = 26;
  localparam int DEF_NUM_MAPS = 5;

  localparam int DEF_POOL_W = DEF_LINE_W / 2;
  localparam int DEF_POOL_H = DEF_ROWS / 2;

  // Counter width for a 0..n-1 range, never zero bits wide.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CW = cw(DEF_LINE_W);
  localparam int DEF_RW = cw(DEF_ROWS);
  localparam int DEF_MW = cw(DEF_NUM_MAPS);

endpackage

// File: rtl/pool2x2_if.sv
// Pixel stream in, pooled stream out, with framing.
// master drives pixels; slave is the pooling stage.
interface pool2x2_if
  import cnn_pool_pkg::*;
#(
  parameter int DW = DEF_DW
) ();

  logic [DW-1:0] pix_in;
  logic          in_valid;
  logic          line_start_in;
  logic          frame_start_dim_in;
  logic          frame_end_dim_in;

  logic [DW-1:0] pool_out;
  logic          out_valid;
  logic          line_start_out;
  logic          frame_start_dim_out;
  logic          frame_end_dim_out;
  logic          err_align;

  modport master (
    output pix_in, in_valid, line_start_in,
    output frame_start_dim_in, frame_end_dim_in,
    input  pool_out, out_valid, line_start_out,
    input  frame_start_dim_out, frame_end_dim_out,
    input  err_align
  );

  modport slave (
    input  pix_in, in_valid, line_start_in,
    input  frame_start_dim_in, frame_end_dim_in,
    output pool_out, out_valid, line_start_out,
    output frame_start_dim_out, frame_end_dim_out,
    output err_align
  );

endinterface

// File: rtl/pool2x2_row_buf.sv
// Row buffer of horizontal maxima from the even row.
// One synchronous write port, one combinational read port.
module pool_row_buf
  import cnn_pool_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_POOL_W,
  parameter int AW    = cw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Store one horizontal max per pooled column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool2x2_top.sv
// 2x2 stride-2 max pooling over a raster pixel stream.
// Counters track (col,row,map); outputs are registered.
module pool2x2_top
  import cnn_pool_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int LINE_W   = DEF_LINE_W,
  parameter int ROWS     = DEF_ROWS,
  parameter int NUM_MAPS = DEF_NUM_MAPS
) (
  input  logic     clk,
  input  logic     rst_n,
  pool2x2_if.slave io
);

  localparam int POOL_W = LINE_W / 2;
  localparam int POOL_H = ROWS / 2;
  localparam int CW = cw(LINE_W);
  localparam int RW = cw(ROWS);
  localparam int MW = cw(NUM_MAPS);
  localparam int AW = cw(POOL_W);

  localparam logic [CW-1:0] C_LAST = CW'(LINE_W - 1);
  localparam logic [CW-1:0] C_END  = CW'(2 * POOL_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] R_END  = RW'(2 * POOL_H - 1);
  localparam logic [MW-1:0] M_LAST = MW'(NUM_MAPS - 1);

  logic [CW-1:0] col, e_col, nx_col;
  logic [RW-1:0] row, e_row, nx_row;
  logic [MW-1:0] map, e_map, nx_map;
  logic [DW-1:0] hold, hmax, rd_data, omax;
  logic [AW-1:0] buf_addr;
  logic          mis, in_c, in_r;
  logic          take_h, wr_en, fire, last_q;

  assign mis = io.in_valid && io.line_start_in &&
               !io.frame_start_dim_in && (col != '0);

  // Effective position of this pixel after start/realign.
  always_comb begin
    e_col = col;
    e_row = row;
    e_map = map;
    if (io.frame_start_dim_in) begin
      e_col = '0;
      e_row = '0;
      e_map = '0;
    end else if (mis) begin
      e_col = '0;
      if (row == R_LAST) begin
        e_row = '0;
        e_map = (map == M_LAST) ? '0 : map + 1'b1;
      end else begin
        e_row = row + 1'b1;
      end
    end
  end

  // Raster advance from the effective position.
  always_comb begin
    nx_col = e_col + 1'b1;
    nx_row = e_row;
    nx_map = e_map;
    if (e_col == C_LAST) begin
      nx_col = '0;
      if (e_row == R_LAST) begin
        nx_row = '0;
        nx_map = (e_map == M_LAST) ? '0 : e_map + 1'b1;
      end else begin
        nx_row = e_row + 1'b1;
      end
    end
  end

  assign in_c     = (e_col <= C_END);
  assign in_r     = (e_row <= R_END);
  assign take_h   = io.in_valid && !e_col[0] && in_c;
  assign wr_en    = io.in_valid && e_col[0] && in_c && !e_row[0];
  assign fire     = io.in_valid && e_col[0] && in_c &&
                    e_row[0] && in_r;
  assign buf_addr = AW'(e_col >> 1);
  assign hmax     = (io.pix_in > hold) ? io.pix_in : hold;
  assign omax     = (rd_data > hmax) ? rd_data : hmax;

  pool_row_buf #(
    .DW    (DW),
    .DEPTH (POOL_W),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (buf_addr),
    .wr_data (hmax),
    .rd_addr (buf_addr),
    .rd_data (rd_data)
  );

  // Position counters; end-of-group clears after use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      map <= '0;
    end else if (io.frame_end_dim_in &&
                 !io.frame_start_dim_in) begin
      col <= '0;
      row <= '0;
      map <= '0;
    end else if (io.in_valid) begin
      col <= nx_col;
      row <= nx_row;
      map <= nx_map;
    end else if (io.frame_start_dim_in) begin
      col <= '0;
      row <= '0;
      map <= '0;
    end
  end

  // Left pixel of each horizontal pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (io.frame_end_dim_in &&
                 !io.frame_start_dim_in) begin
      hold <= '0;
    end else if (take_h) begin
      hold <= io.pix_in;
    end else if (io.frame_start_dim_in) begin
      hold <= '0;
    end
  end

  // Sticky misalignment flag, cleared by group start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.err_align <= 1'b0;
    end else if (io.frame_start_dim_in) begin
      io.err_align <= 1'b0;
    end else if (mis) begin
      io.err_align <= 1'b1;
    end
  end

  // Registered pooled output and framing pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.pool_out            <= '0;
      io.out_valid           <= 1'b0;
      io.line_start_out      <= 1'b0;
      io.frame_start_dim_out <= 1'b0;
      io.frame_end_dim_out   <= 1'b0;
      last_q                 <= 1'b0;
    end else begin
      if (fire) io.pool_out <= omax;
      io.out_valid           <= fire;
      io.line_start_out      <= fire && (e_col == CW'(1));
      io.frame_start_dim_out <= fire && (e_col == CW'(1)) &&
                                (e_row == RW'(1)) &&
                                (e_map == '0);
      last_q                 <= fire && (e_col == C_END) &&
                                (e_row == R_END) &&
                                (e_map == M_LAST);
      io.frame_end_dim_out   <= last_q;
    end
  end

endmodule

// File: tb/tb_pool2x2_top.sv
// Bench for pool2x2_top: vector table, reference model,
// gap, odd-size, realign and mid-frame reset sequences.
module tb_pool2x2_top;

  typedef struct {
    bit          v;
    logic [15:0] pix;
    bit          ls;
    bit          fs;
    bit          fe;
    bit          e_v;
    int          e_out;
    bit          e_ls;
    bit          e_fs;
    bit          e_fe;
  } vec_t;

  typedef struct {
    int val;
    bit ls;
    bit fs;
    int cyc;
  } obs_t;

  typedef struct {
    int val;
    bit ls;
    bit fs;
    int pix;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  int   img[$];
  int   drv_cyc[$];
  exp_t exp_q[$];
  obs_t q4[$], q26[$], q5[$];
  int   fe4[$], fe26[$], fe5[$];

  pool2x2_if #(.DW(16)) i4 ();
  pool2x2_if #(.DW(16)) i26 ();
  pool2x2_if #(.DW(16)) i5 ();

  pool2x2_top #(
    .LINE_W(4), .ROWS(4), .NUM_MAPS(1)
  ) d4 (
    .clk(clk), .rst_n(rst_n), .io(i4.slave)
  );

  pool2x2_top d26 (
    .clk(clk), .rst_n(rst_n), .io(i26.slave)
  );

  pool2x2_top #(
    .LINE_W(5), .ROWS(5), .NUM_MAPS(1)
  ) d5 (
    .clk(clk), .rst_n(rst_n), .io(i5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (i4.out_valid)
      q4.push_back('{int'(i4.pool_out), i4.line_start_out,
                     i4.frame_start_dim_out, cyc});
    if (i4.frame_end_dim_out) fe4.push_back(cyc);
    if (i26.out_valid)
      q26.push_back('{int'(i26.pool_out), i26.line_start_out,
                      i26.frame_start_dim_out, cyc});
    if (i26.frame_end_dim_out) fe26.push_back(cyc);
    if (i5.out_valid)
      q5.push_back('{int'(i5.pool_out), i5.line_start_out,
                     i5.frame_start_dim_out, cyc});
    if (i5.frame_end_dim_out) fe5.push_back(cyc);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(int sel, bit v, logic [15:0] p,
                        bit ls, bit fs, bit fe);
    case (sel)
      0: begin
        i4.in_valid = v; i4.pix_in = p; i4.line_start_in = ls;
        i4.frame_start_dim_in = fs; i4.frame_end_dim_in = fe;
      end
      1: begin
        i26.in_valid = v; i26.pix_in = p; i26.line_start_in = ls;
        i26.frame_start_dim_in = fs; i26.frame_end_dim_in = fe;
      end
      default: begin
        i5.in_valid = v; i5.pix_in = p; i5.line_start_in = ls;
        i5.frame_start_dim_in = fs; i5.frame_end_dim_in = fe;
      end
    endcase
  endtask

  task automatic clear_q(int sel);
    case (sel)
      0: begin q4.delete(); fe4.delete(); end
      1: begin q26.delete(); fe26.delete(); end
      default: begin q5.delete(); fe5.delete(); end
    endcase
  endtask

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Expected pooled outputs straight from the image array.
  task automatic build_exp(int w, int h, int m);
    int b;
    exp_q.delete();
    for (int mm = 0; mm < m; mm++)
      for (int pr = 0; pr < h / 2; pr++)
        for (int pc = 0; pc < w / 2; pc++) begin
          b = (mm * h + 2 * pr) * w + 2 * pc;
          exp_q.push_back('{
            max2(max2(img[b], img[b + 1]),
                 max2(img[b + w], img[b + w + 1])),
            pc == 0, (b == 0), b + w + 1});
        end
  endtask

  task automatic run_stream(int sel, int w, int h, int m,
                            int gapmax, bit use_fs);
    int n;
    int g;
    n = w * h * m;
    clear_q(sel);
    drv_cyc.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_in(sel, 1'b1, 16'(img[i]), (i % w) == 0,
             use_fs && (i == 0), i == n - 1);
      drv_cyc.push_back(cyc);
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (g) begin
        @(posedge clk); #1;
        set_in(sel, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      end
    end
    @(posedge clk); #1;
    set_in(sel, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(int sel, string tag);
    obs_t got[$];
    int   fes[$];
    int   n;
    case (sel)
      0: begin got = q4; fes = fe4; end
      1: begin got = q26; fes = fe26; end
      default: begin got = q5; fes = fe5; end
    endcase
    chk({tag, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, "_val"}, got[k].val, exp_q[k].val);
      chk({tag, "_ls"}, 32'(got[k].ls), 32'(exp_q[k].ls));
      chk({tag, "_fs"}, 32'(got[k].fs), 32'(exp_q[k].fs));
      chk({tag, "_lat"}, got[k].cyc,
          drv_cyc[exp_q[k].pix] + 1);
    end
    chk({tag, "_fe_count"}, fes.size(), 1);
    if (fes.size() > 0 && got.size() > 0)
      chk({tag, "_fe_cyc"}, fes[0], got[got.size() - 1].cyc + 1);
  endtask

  task automatic check_4x4_consts(string tag);
    int k4[4];
    k4 = '{5, 7, 13, 15};
    for (int k = 0; k < 4; k++)
      chk(tag, (k < q4.size()) ? q4[k].val : -1, k4[k]);
  endtask

  vec_t tbl[17];

  initial begin
    int av[13];
    bit al[13];
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int s = 0; s < 3; s++)
      set_in(s, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      tbl[i].v = 1'b1; tbl[i].pix = 16'(i);
      tbl[i].ls = (i % 4) == 0; tbl[i].fs = (i == 0);
      tbl[i].fe = (i == 15);
      tbl[i].e_v = 1'b0; tbl[i].e_out = 0;
      tbl[i].e_ls = 1'b0; tbl[i].e_fs = 1'b0; tbl[i].e_fe = 1'b0;
    end
    tbl[16] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 0, 1'b0, 1'b0, 1'b1};
    tbl[5].e_v = 1;  tbl[5].e_out = 5;
    tbl[5].e_ls = 1; tbl[5].e_fs = 1;
    tbl[7].e_v = 1;  tbl[7].e_out = 7;
    tbl[13].e_v = 1; tbl[13].e_out = 13; tbl[13].e_ls = 1;
    tbl[15].e_v = 1; tbl[15].e_out = 15;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pool_out", i4.pool_out, 0);
    chk("rst_out_valid", i4.out_valid, 0);
    chk("rst_ls_out", i4.line_start_out, 0);
    chk("rst_fs_out", i4.frame_start_dim_out, 0);
    chk("rst_fe_out", i4.frame_end_dim_out, 0);
    chk("rst_err", i4.err_align, 0);
    chk("rst_valid26", i26.out_valid, 0);
    rst_n = 1'b1;

    // 4x4 vector table, checked every cycle.
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        chk("tbl_valid", i4.out_valid, tbl[i - 1].e_v);
        chk("tbl_ls", i4.line_start_out, tbl[i - 1].e_ls);
        chk("tbl_fs", i4.frame_start_dim_out, tbl[i - 1].e_fs);
        chk("tbl_fe", i4.frame_end_dim_out, tbl[i - 1].e_fe);
        chk("tbl_err", i4.err_align, 0);
        if (tbl[i - 1].e_v)
          chk("tbl_out", i4.pool_out, tbl[i - 1].e_out);
      end
      if (i < 17)
        set_in(0, tbl[i].v, tbl[i].pix, tbl[i].ls,
               tbl[i].fs, tbl[i].fe);
    end
    repeat (3) @(posedge clk);
    #1;

    // Default geometry, five maps of the xor pattern.
    img.delete();
    for (int m = 0; m < 5; m++)
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++)
          img.push_back((r * 26 + c) ^ 16'h00FF);
    build_exp(26, 26, 5);
    run_stream(1, 26, 26, 5, 0, 1'b1);
    check_stream(1, "pat26");

    // Default geometry, random pixels with short gaps.
    img.delete();
    for (int i = 0; i < 26 * 26 * 5; i++)
      img.push_back(int'($urandom_range(65535, 0)));
    build_exp(26, 26, 5);
    run_stream(1, 26, 26, 5, 1, 1'b1);
    check_stream(1, "rnd26");

    // 4x4 with random 0..3 cycle gaps.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(i);
    build_exp(4, 4, 1);
    run_stream(0, 4, 4, 1, 3, 1'b1);
    check_stream(0, "gap4");
    check_4x4_consts("gap4_const");

    // 5x5: trailing column and row dropped.
    img.delete();
    for (int i = 0; i < 25; i++) img.push_back(i);
    build_exp(5, 5, 1);
    run_stream(2, 5, 5, 1, 0, 1'b1);
    check_stream(2, "odd5");
    begin
      int k5[4];
      k5 = '{6, 8, 16, 18};
      for (int k = 0; k < 4; k++)
        chk("odd5_const", (k < q5.size()) ? q5[k].val : -1, k5[k]);
    end

    // Line start at col 2 of row 1 realigns to row 2.
    av = '{1, 2, 3, 4, 5, 6, 10, 11, 12, 13, 20, 21, 22};
    al = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0};
    clear_q(0);
    for (int j = 0; j < 14; j++) begin
      @(posedge clk); #1;
      if (j > 0) chk("align_err_seq", i4.err_align, (j > 6));
      if (j < 13)
        set_in(0, 1'b1, 16'(av[j]), al[j], j == 0, 1'b0);
      else
        set_in(0, 1'b1, 16'd23, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("align_count", q4.size(), 3);
    chk("align_v0", (q4.size() > 0) ? q4[0].val : -1, 6);
    chk("align_v1", (q4.size() > 1) ? q4[1].val : -1, 21);
    chk("align_v2", (q4.size() > 2) ? q4[2].val : -1, 23);
    chk("align_ls1", (q4.size() > 1) ? 32'(q4[1].ls) : 2, 1);
    chk("align_fe", fe4.size(), 1);
    chk("align_err", i4.err_align, 1);
    set_in(0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("align_err_clr", i4.err_align, 0);

    // Reset mid-map, then a fresh stream without start.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      set_in(0, 1'b1, 16'(i + 100), (i % 4) == 0 || i == 6,
             i == 0, 1'b0);
    end
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid_err_set", i4.err_align, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pool_out", i4.pool_out, 0);
    chk("mid_rst_valid", i4.out_valid, 0);
    chk("mid_rst_ls", i4.line_start_out, 0);
    chk("mid_rst_fs", i4.frame_start_dim_out, 0);
    chk("mid_rst_fe", i4.frame_end_dim_out, 0);
    chk("mid_rst_err", i4.err_align, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(i);
    build_exp(4, 4, 1);
    run_stream(0, 4, 4, 1, 0, 1'b0);
    check_stream(0, "post_rst");
    check_4x4_consts("post_rst_const");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
